// File: rtl/sevenseg_bcd_display_seq.sv
// N-digit seven-segment driver: valid/ready capture, windowed refresh, sequential double-dabble; tick->display in VALUE_W+2 cycles.
// Ready only in IDLE/WAIT (beats dropped while converting). Optional build macro SEVENSEG_PEAK_HOLD_EN keeps the window's maximum.
module sevenseg_bcd_display_seq #(
   parameter int VALUE_W       = 16,
   parameter int NUM_DIGITS    = 4,
   parameter int UPDATE_CYCLES = 12_500_000,
   parameter int ACTIVE_LOW    = 1,
   parameter int BLANK_LZ      = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    value_valid,
   input  logic [VALUE_W-1:0]      value,
   output logic                    value_ready,
   output logic [7*NUM_DIGITS-1:0] hex_out,
   output logic                    overflow,
   output logic                    display_update
);

   // ceil(VALUE_W*log10(2)) + 1 digits, widened so every displayed digit exists in the accumulator
   localparam int CALC_DIGITS = (VALUE_W * 30103 + 99999) / 100000 + 1;
   localparam int ACC_DIGITS  = (CALC_DIGITS > NUM_DIGITS) ? CALC_DIGITS : NUM_DIGITS;
   localparam int ACC_W       = 4 * ACC_DIGITS;
   localparam int TMR_W       = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
   localparam int CNT_W       = $clog2(VALUE_W + 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] POL_MASK  = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
   localparam logic [7*NUM_DIGITS-1:0] HEX_RST = {NUM_DIGITS{SEG_BLANK ^ POL_MASK}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CONVERT,
      S_LOAD
   } state_t;

   state_t                  state_q, state_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic [VALUE_W-1:0]      sample_q, sample_d, sample_nxt;
   logic [VALUE_W-1:0]      shift_q, shift_d;
   logic [ACC_W-1:0]        bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [7*NUM_DIGITS-1:0] hex_q, hex_d, hex_nxt;
   logic                    ovf_q, ovf_d, ovf_nxt;
   logic                    upd_q, upd_d;
   logic                    tick;
   logic                    accept;

   function automatic logic [6:0] seg_raw(input logic [3:0] d);
      case (d)
         4'd0:    seg_raw = 7'b1000000;
         4'd1:    seg_raw = 7'b1111001;
         4'd2:    seg_raw = 7'b0100100;
         4'd3:    seg_raw = 7'b0110000;
         4'd4:    seg_raw = 7'b0011001;
         4'd5:    seg_raw = 7'b0010010;
         4'd6:    seg_raw = 7'b0000010;
         4'd7:    seg_raw = 7'b1111000;
         4'd8:    seg_raw = 7'b0000000;
         4'd9:    seg_raw = 7'b0010000;
         default: seg_raw = SEG_BLANK;
      endcase
   endfunction

   assign tick        = (timer_q == TMR_W'(UPDATE_CYCLES - 1));
   assign timer_d     = tick ? '0 : timer_q + 1'b1;
   assign value_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_WAIT));
   assign accept      = value_valid && value_ready;

`ifdef SEVENSEG_PEAK_HOLD_EN
   assign sample_nxt = (accept && (value > sample_q)) ? value : sample_q;
`else
   assign sample_nxt = accept ? value : sample_q;
`endif

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < ACC_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Overflow forces dashes; otherwise blank every digit above the leading nonzero one
   always_comb begin
      logic       seen;
      logic [3:0] nib;
      logic [6:0] raw;
      ovf_nxt = 1'b0;
      hex_nxt = '0;
      seen    = 1'b0;
      nib     = '0;
      raw     = SEG_BLANK;
      for (int i = NUM_DIGITS; i < ACC_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) begin
            ovf_nxt = 1'b1;
         end
      end
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         nib = bcd_q[4*k +: 4];
         if (nib != 4'd0) begin
            seen = 1'b1;
         end
         if (ovf_nxt) begin
            raw = SEG_DASH;
         end else if ((BLANK_LZ != 0) && !seen && (k != 0)) begin
            raw = SEG_BLANK;
         end else begin
            raw = seg_raw(nib);
         end
         hex_nxt[7*k +: 7] = raw ^ POL_MASK;
      end
   end

   always_comb begin
      state_d  = state_q;
      sample_d = sample_q;
      shift_d  = shift_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      hex_d    = hex_q;
      ovf_d    = ovf_q;
      upd_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sample_d = value;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tick) begin
               shift_d  = sample_nxt;
               sample_d = '0;
               bcd_d    = '0;
               cnt_d    = '0;
               state_d  = S_CONVERT;
            end else begin
               sample_d = sample_nxt;
            end
         end
         S_CONVERT: begin
            bcd_d   = {bcd_adj[ACC_W-2:0], shift_q[VALUE_W-1]};
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(VALUE_W - 1)) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            hex_d   = hex_nxt;
            ovf_d   = ovf_nxt;
            upd_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         sample_q <= '0;
         shift_q  <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         hex_q    <= HEX_RST;
         ovf_q    <= 1'b0;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         sample_q <= sample_d;
         shift_q  <= shift_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         hex_q    <= hex_d;
         ovf_q    <= ovf_d;
         upd_q    <= upd_d;
      end
   end

   assign hex_out        = hex_q;
   assign overflow       = ovf_q;
   assign display_update = upd_q;

endmodule
